mc_cpu_ctrl: RTL and testbench
==============================

// Module: mc_cpu_ctrl
// PURPOSE
//  Parametrised multicycle CPU controller: owns PC and IR, sequences fetch/decode/execute, and drives
//  the existing register-file/ALU datapath and a handshaked memory port. Adds load/store, Bcond/Jcond,
//  HALT and memory wait states. Sits between the instruction/data memory and the RegALU datapath in top.
// PARAMETERS
//  DATA_W    16  datapath/instruction width (instruction field positions below assume 16)
//  ADDR_W    10  memory address width; PC width
//  REG_IDX_W 4   register index width (2**REG_IDX_W registers)
//  RESET_PC  0   PC value after reset
// PORTS
//  clk       in   1          clock; all state updates on rising edge
//  rst       in   1          synchronous, active-high reset
//  mem_req   out  1          memory access request; held until mem_ready
//  mem_we    out  1          write strobe, valid with mem_req
//  mem_addr  out  ADDR_W     access address
//  mem_wdata out  DATA_W     store data (= ra_data)
//  mem_rdata in   DATA_W     read data, valid in the mem_ready cycle
//  mem_ready in   1          access completes this cycle
//  ra_idx    out  REG_IDX_W  port A / destination index = IR[11:8]
//  rb_idx    out  REG_IDX_W  port B / address index = IR[3:0]
//  ra_data   in   DATA_W     register A read data (combinational)
//  rb_data   in   DATA_W     register B read data (combinational)
//  alu_op    out  8          {IR[15:12],IR[7:4]} for op 0000, else {IR[15:12],4'b0}
//  imm       out  DATA_W     IR[7:0] zero-extended
//  sel_imm   out  1          1 when op != 0000 (immediate ALU form)
//  reg_we    out  1          register write enable, one-cycle pulse
//  wb_sel    out  1          writeback source: 0 ALU, 1 mem_rdata
//  flags     in   5          {N,Z,F,L,C} = flags[4:0] from ALU flag register
//  pc        out  ADDR_W     current PC
//  halted    out  1          HALT executed
// BEHAVIOUR
//  Reset: pc=RESET_PC, IR=0, state=FETCH, halted=0; all strobes (mem_req,mem_we,reg_we,wb_sel) 0.
//  Reset wins over every event, including mid-access; an access in flight is abandoned.
//  States: FETCH, DECODE, EXEC, MEM, BRANCH, HALT. Outputs are decoded from state+IR (Moore).
//  FETCH: mem_req=1, mem_we=0, mem_addr=pc. Stay until mem_ready; then IR<=mem_rdata, go to DECODE.
//  DECODE: one cycle, no strobes; ra/rb indices settle. Next state by IR[15:12]/IR[7:4]:
//   0100/0000 LOAD, 0100/0100 STOR -> MEM; 1100 Bcond, 0100/1100 Jcond -> BRANCH; 1111 -> HALT;
//   all other encodings -> EXEC.
//  EXEC: reg_we=1 except CMP (op 0000 ext 1011) and CMPI (op 1011); pc<=pc+1; go to FETCH.
//   Undefined ALU sub-ops pass through; the datapath treats them as NOP.
//  MEM: mem_req=1, mem_addr=rb_data[ADDR_W-1:0]. LOAD: mem_we=0; in the mem_ready cycle
//   reg_we=1, wb_sel=1. STOR: mem_we=1, mem_wdata=ra_data. On mem_ready: pc<=pc+1, go to FETCH.
//  BRANCH: cond=IR[11:8]. EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; GT 0110 N; LE 0111 !N;
//   FS 1000 F; FC 1001 !F; LO 1010 L; HS 1011 !L; UC 1110 1; all others 0 (never taken).
//   Bcond taken: pc<=pc+sext(IR[7:0]). Jcond taken: pc<=rb_data[ADDR_W-1:0]. Not taken: pc+1.
//   Go to FETCH.
//  HALT: halted=1, pc frozen, no strobes; exit only by rst.
//  Latency at zero-wait memory (mem_ready tied 1): ALU/branch 3 cycles, LOAD/STOR 4.
//   Each wait cycle adds 1.
//  PC arithmetic is modulo 2**ADDR_W; wrap 2**ADDR_W-1 -> 0 and negative displacements wrap silently.
//  mem_ready outside FETCH/MEM is ignored. The controller never writes flags.
// TESTING
//  ALU: mem[0]=0x0153 (ADD r1,r3), ready tied 1 -> reg_we pulse 3rd cycle after rst, alu_op=0x05,
//   sel_imm=0, pc=1.
//  LOAD, 2 wait states: r2=0x0040, inst 0x4502 -> mem_req addr 0x040 held 3 cycles;
//   reg_we&wb_sel only in ready cycle; pc+1.
//  STOR: r5=0xBEEF, r2=0x0010, inst 0x4542 -> single mem_we cycle, addr 0x010, wdata 0xBEEF.
//  Bcond: pc=5, inst 0xC0FD, Z=1 -> pc=2; same with Z=0 -> pc=6; at pc=0 disp -1 -> pc=0x3FF.
//  HALT at pc=7 (0xF000) -> halted=1, pc stays 7 for 20 cycles; rst -> pc=0, halted=0.
//  rst asserted during MEM wait -> next cycle mem_req=0, state FETCH, pc=RESET_PC.

Source files
------------

// File: rtl/mc_cpu_ctrl.sv
// mc_cpu_ctrl: multicycle CPU controller.
//   Owns PC and IR and steps each instruction through FETCH -> DECODE -> EXEC/MEM/BRANCH/HALT.
//   It drives the register-file/ALU datapath and a request/ready memory port.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_req/we/addr/wdata     memory request, write strobe, address, store data
//   mem_rdata, mem_ready      memory read data, access-complete strobe
//   ra_idx, rb_idx            register A (destination) and register B (address) indices
//   ra_data, rb_data          register read data (combinational from the indices)
//   alu_op, imm, sel_imm      ALU operation code, zero-extended immediate, immediate select
//   reg_we, wb_sel            register write pulse, writeback source (0 ALU, 1 memory)
//   flags                     {N,Z,F,L,C} from the ALU flag register
//   pc, halted                current PC, HALT executed
module mc_cpu_ctrl #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned REG_IDX_W = 4,
   parameter int unsigned RESET_PC  = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic [DATA_W-1:0]    mem_rdata,
   input  logic                 mem_ready,
   output logic [REG_IDX_W-1:0] ra_idx,
   output logic [REG_IDX_W-1:0] rb_idx,
   input  logic [DATA_W-1:0]    ra_data,
   input  logic [DATA_W-1:0]    rb_data,
   output logic [7:0]           alu_op,
   output logic [DATA_W-1:0]    imm,
   output logic                 sel_imm,
   output logic                 reg_we,
   output logic                 wb_sel,
   input  logic [4:0]           flags,
   output logic [ADDR_W-1:0]    pc,
   output logic                 halted
);

   localparam logic [3:0] OP_ALU    = 4'b0000;
   localparam logic [3:0] OP_MEMJ   = 4'b0100;
   localparam logic [3:0] OP_CMPI   = 4'b1011;
   localparam logic [3:0] OP_BCOND  = 4'b1100;
   localparam logic [3:0] OP_HALT   = 4'b1111;
   localparam logic [3:0] EXT_LOAD  = 4'b0000;
   localparam logic [3:0] EXT_STOR  = 4'b0100;
   localparam logic [3:0] EXT_JCOND = 4'b1100;
   localparam logic [3:0] EXT_CMP   = 4'b1011;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_BRANCH = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   pc_q, pc_nxt;
   logic [DATA_W-1:0]   ir_q, ir_nxt;

   logic [3:0]          op, ext, cond;
   logic                is_load, is_stor, is_jcond, is_bcond, is_cmp, is_cmpi;
   logic                cond_true;
   logic [ADDR_W-1:0]   pc_inc, disp, rb_addr;
   logic                unused_rb;

   // Instruction field decode
   assign op       = ir_q[15:12];
   assign cond     = ir_q[11:8];
   assign ext      = ir_q[7:4];
   assign is_load  = (op == OP_MEMJ) && (ext == EXT_LOAD);
   assign is_stor  = (op == OP_MEMJ) && (ext == EXT_STOR);
   assign is_jcond = (op == OP_MEMJ) && (ext == EXT_JCOND);
   assign is_bcond = (op == OP_BCOND);
   assign is_cmp   = (op == OP_ALU) && (ext == EXT_CMP);
   assign is_cmpi  = (op == OP_CMPI);

   // PC arithmetic wraps modulo 2**ADDR_W
   assign pc_inc    = pc_q + ADDR_W'(1);
   assign disp      = ADDR_W'($signed(ir_q[7:0]));
   assign rb_addr   = rb_data[ADDR_W-1:0];
   assign unused_rb = ^rb_data[DATA_W-1:ADDR_W];

   // Datapath controls decoded from IR
   assign ra_idx    = ir_q[8 +: REG_IDX_W];
   assign rb_idx    = ir_q[0 +: REG_IDX_W];
   assign alu_op    = (op == OP_ALU) ? {op, ext} : {op, 4'b0000};
   assign imm       = DATA_W'(ir_q[7:0]);
   assign sel_imm   = (op != OP_ALU);
   assign mem_wdata = ra_data;
   assign pc        = pc_q;
   assign halted    = (state == S_HALT);

   // Branch condition evaluation; flags = {N,Z,F,L,C}
   always_comb begin
      cond_true = 1'b0;
      case (cond)
         4'b0000: cond_true = flags[3];
         4'b0001: cond_true = ~flags[3];
         4'b0010: cond_true = flags[0];
         4'b0011: cond_true = ~flags[0];
         4'b0110: cond_true = flags[4];
         4'b0111: cond_true = ~flags[4];
         4'b1000: cond_true = flags[2];
         4'b1001: cond_true = ~flags[2];
         4'b1010: cond_true = flags[1];
         4'b1011: cond_true = ~flags[1];
         4'b1110: cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

   // State, PC and IR registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
         pc_q  <= ADDR_W'(RESET_PC);
         ir_q  <= '0;
      end else begin
         state <= state_nxt;
         pc_q  <= pc_nxt;
         ir_q  <= ir_nxt;
      end
   end

   // Next-state and strobe decode
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_q;
      ir_nxt    = ir_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc_q;
      reg_we    = 1'b0;
      wb_sel    = 1'b0;

      case (state)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_nxt    = mem_rdata;
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            if (is_load || is_stor)
               state_nxt = S_MEM;
            else if (is_bcond || is_jcond)
               state_nxt = S_BRANCH;
            else if (op == OP_HALT)
               state_nxt = S_HALT;
            else
               state_nxt = S_EXEC;
         end
         S_EXEC: begin
            reg_we    = ~(is_cmp | is_cmpi);
            pc_nxt    = pc_inc;
            state_nxt = S_FETCH;
         end
         S_MEM: begin
            mem_req  = 1'b1;
            mem_we   = is_stor;
            mem_addr = rb_addr;
            // Load writeback happens in the completing cycle only
            if (mem_ready) begin
               reg_we    = is_load;
               wb_sel    = is_load;
               pc_nxt    = pc_inc;
               state_nxt = S_FETCH;
            end
         end
         S_BRANCH: begin
            if (cond_true)
               pc_nxt = is_jcond ? rb_addr : (pc_q + disp);
            else
               pc_nxt = pc_inc;
            state_nxt = S_FETCH;
         end
         S_HALT: begin
            state_nxt = S_HALT;
         end
         default: begin
            state_nxt = S_FETCH;
         end
      endcase

      // Strobes are quiet while reset is held so an abandoned access drops at once
      if (rst) begin
         mem_req = 1'b0;
         mem_we  = 1'b0;
         reg_we  = 1'b0;
         wb_sel  = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_cpu_ctrl.sv
// tb_mc_cpu_ctrl: directed bench for mc_cpu_ctrl with a wait-state memory and a register array.
module tb_mc_cpu_ctrl;

   logic        clk;
   logic        rst;
   logic        mem_req, mem_we, mem_ready;
   logic [9:0]  mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic [3:0]  ra_idx, rb_idx;
   logic [15:0] ra_data, rb_data;
   logic [7:0]  alu_op;
   logic [15:0] imm;
   logic        sel_imm, reg_we, wb_sel;
   logic [4:0]  flags;
   logic [9:0]  pc;
   logic        halted;

   logic [15:0] mem  [0:1023];
   logic [15:0] regs [0:15];
   int          wait_n = 0;
   int          wcnt = 0;
   int          store_cnt = 0;
   logic [9:0]  st_addr = '0;
   logic [15:0] st_data = '0;
   int          n_pass = 0;
   int          n_total = 0;

   mc_cpu_ctrl dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .ra_idx(ra_idx), .rb_idx(rb_idx), .ra_data(ra_data), .rb_data(rb_data),
      .alu_op(alu_op), .imm(imm), .sel_imm(sel_imm), .reg_we(reg_we), .wb_sel(wb_sel),
      .flags(flags), .pc(pc), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];
   assign ra_data   = regs[ra_idx];
   assign rb_data   = regs[rb_idx];
   assign mem_ready = mem_req && (wcnt == wait_n);

   // Wait-state counter: ready after wait_n stalled cycles of a request
   always @(posedge clk) begin
      if (rst || !mem_req || mem_ready) wcnt <= 0;
      else                              wcnt <= wcnt + 1;
   end

   always @(posedge clk) begin
      if (mem_req && mem_we && mem_ready) begin
         store_cnt <= store_cnt + 1;
         st_addr   <= mem_addr;
         st_data   <= mem_wdata;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_mem(input logic [15:0] w);
      for (int i = 0; i < 1024; i++) mem[i] = w;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      wait_n = 0;
      flags  = 5'b0;
      fill_mem(16'h0100);
      rst = 1'b1;
      step();
      step();
      n_total++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", mem_req); else n_pass++;
      n_total++; if (reg_we !== 1'b0) $display("FAIL rst_reg_we: got %b want 0", reg_we); else n_pass++;
      n_total++; if (pc !== 10'h000) $display("FAIL rst_pc: got %h want 000", pc); else n_pass++;
      n_total++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted); else n_pass++;
      rst = 1'b0;
      #1;
      n_total++; if (mem_req !== 1'b1 || mem_addr !== 10'h000)
         $display("FAIL rst_fetch: got req=%b addr=%h want req=1 addr=000", mem_req, mem_addr); else n_pass++;
   endtask

   task automatic test_alu();
      wait_n = 0;
      fill_mem(16'h0100);
      mem[0] = 16'h0153;
      mem[1] = 16'h01B3;
      mem[2] = 16'hB107;
      do_reset();
      step();
      n_total++; if (reg_we !== 1'b0 || mem_req !== 1'b0 || ra_idx !== 4'd1 || rb_idx !== 4'd3)
         $display("FAIL alu_decode: got we=%b req=%b ra=%h rb=%h want 0 0 1 3", reg_we, mem_req, ra_idx, rb_idx); else n_pass++;
      step();
      n_total++; if (reg_we !== 1'b1 || alu_op !== 8'h05 || sel_imm !== 1'b0)
         $display("FAIL alu_exec: got we=%b op=%h imm_sel=%b want 1 05 0", reg_we, alu_op, sel_imm); else n_pass++;
      step();
      n_total++; if (pc !== 10'h001 || reg_we !== 1'b0)
         $display("FAIL alu_pc: got pc=%h we=%b want 001 0", pc, reg_we); else n_pass++;
      step();
      step();
      n_total++; if (reg_we !== 1'b0 || alu_op !== 8'h0B)
         $display("FAIL cmp_exec: got we=%b op=%h want 0 0b", reg_we, alu_op); else n_pass++;
      step();
      step();
      step();
      n_total++; if (reg_we !== 1'b0 || sel_imm !== 1'b1 || alu_op !== 8'hB0 || imm !== 16'h0007)
         $display("FAIL cmpi_exec: got we=%b sel=%b op=%h imm=%h want 0 1 b0 0007", reg_we, sel_imm, alu_op, imm); else n_pass++;
      step();
      n_total++; if (pc !== 10'h003) $display("FAIL cmpi_pc: got %h want 003", pc); else n_pass++;
   endtask

   task automatic test_load();
      wait_n = 2;
      fill_mem(16'h0100);
      mem[0]     = 16'h4502;
      mem[10'h040] = 16'h1234;
      regs[2]    = 16'h0040;
      do_reset();
      for (int i = 0; i < 4; i++) step();
      n_total++; if (mem_req !== 1'b1 || mem_addr !== 10'h040 || mem_we !== 1'b0 || reg_we !== 1'b0)
         $display("FAIL load_mem1: got req=%b addr=%h we=%b rwe=%b want 1 040 0 0", mem_req, mem_addr, mem_we, reg_we); else n_pass++;
      step();
      n_total++; if (mem_req !== 1'b1 || mem_addr !== 10'h040 || reg_we !== 1'b0 || wb_sel !== 1'b0)
         $display("FAIL load_mem2: got req=%b addr=%h rwe=%b wb=%b want 1 040 0 0", mem_req, mem_addr, reg_we, wb_sel); else n_pass++;
      step();
      n_total++; if (mem_req !== 1'b1 || mem_addr !== 10'h040 || reg_we !== 1'b1 || wb_sel !== 1'b1 || ra_idx !== 4'd5)
         $display("FAIL load_mem3: got req=%b addr=%h rwe=%b wb=%b ra=%h want 1 040 1 1 5", mem_req, mem_addr, reg_we, wb_sel, ra_idx); else n_pass++;
      step();
      n_total++; if (pc !== 10'h001 || reg_we !== 1'b0 || wb_sel !== 1'b0 || mem_addr !== 10'h001)
         $display("FAIL load_done: got pc=%h rwe=%b wb=%b addr=%h want 001 0 0 001", pc, reg_we, wb_sel, mem_addr); else n_pass++;
   endtask

   task automatic test_store();
      int cnt0;
      wait_n = 0;
      fill_mem(16'h0100);
      mem[0]  = 16'h4542;
      regs[5] = 16'hBEEF;
      regs[2] = 16'h0010;
      do_reset();
      cnt0 = store_cnt;
      step();
      step();
      n_total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'h010 || mem_wdata !== 16'hBEEF || reg_we !== 1'b0)
         $display("FAIL stor_mem: got req=%b we=%b addr=%h wd=%h rwe=%b want 1 1 010 beef 0", mem_req, mem_we, mem_addr, mem_wdata, reg_we); else n_pass++;
      step();
      n_total++; if (mem_we !== 1'b0 || pc !== 10'h001)
         $display("FAIL stor_done: got we=%b pc=%h want 0 001", mem_we, pc); else n_pass++;
      n_total++; if (store_cnt - cnt0 !== 1 || st_addr !== 10'h010 || st_data !== 16'hBEEF)
         $display("FAIL stor_count: got n=%0d addr=%h data=%h want 1 010 beef", store_cnt - cnt0, st_addr, st_data); else n_pass++;
   endtask

   task automatic test_branch();
      wait_n = 0;
      fill_mem(16'h0100);
      mem[5] = 16'hC0FD;
      flags  = 5'b01000;
      do_reset();
      for (int i = 0; i < 15; i++) step();
      n_total++; if (pc !== 10'h005 || mem_addr !== 10'h005)
         $display("FAIL br_reach: got pc=%h addr=%h want 005 005", pc, mem_addr); else n_pass++;
      for (int i = 0; i < 3; i++) step();
      n_total++; if (pc !== 10'h002) $display("FAIL bcond_taken: got %h want 002", pc); else n_pass++;

      flags = 5'b00000;
      do_reset();
      for (int i = 0; i < 18; i++) step();
      n_total++; if (pc !== 10'h006) $display("FAIL bcond_not_taken: got %h want 006", pc); else n_pass++;

      fill_mem(16'h0100);
      mem[0] = 16'hC0FF;
      flags  = 5'b01000;
      do_reset();
      for (int i = 0; i < 3; i++) step();
      n_total++; if (pc !== 10'h3FF || mem_addr !== 10'h3FF)
         $display("FAIL bcond_wrap: got pc=%h addr=%h want 3ff 3ff", pc, mem_addr); else n_pass++;
      for (int i = 0; i < 3; i++) step();
      n_total++; if (pc !== 10'h000) $display("FAIL pc_inc_wrap: got %h want 000", pc); else n_pass++;

      mem[0]  = 16'h4EC3;
      regs[3] = 16'h0123;
      do_reset();
      for (int i = 0; i < 3; i++) step();
      n_total++; if (pc !== 10'h123) $display("FAIL jcond_uc: got %h want 123", pc); else n_pass++;

      mem[0] = 16'h4FC3;
      do_reset();
      for (int i = 0; i < 3; i++) step();
      n_total++; if (pc !== 10'h001) $display("FAIL jcond_never: got %h want 001", pc); else n_pass++;

      mem[0] = 16'hC105;
      flags  = 5'b01000;
      do_reset();
      for (int i = 0; i < 3; i++) step();
      n_total++; if (pc !== 10'h001) $display("FAIL bcond_ne_z: got %h want 001", pc); else n_pass++;

      mem[0] = 16'hC605;
      flags  = 5'b10000;
      do_reset();
      for (int i = 0; i < 3; i++) step();
      n_total++; if (pc !== 10'h005) $display("FAIL bcond_gt_n: got %h want 005", pc); else n_pass++;
      flags = 5'b00000;
   endtask

   task automatic test_halt();
      wait_n = 0;
      fill_mem(16'h0100);
      mem[7] = 16'hF000;
      do_reset();
      for (int i = 0; i < 21; i++) step();
      n_total++; if (pc !== 10'h007 || halted !== 1'b0)
         $display("FAIL halt_reach: got pc=%h halted=%b want 007 0", pc, halted); else n_pass++;
      step();
      step();
      n_total++; if (halted !== 1'b1) $display("FAIL halt_set: got %b want 1", halted); else n_pass++;
      for (int i = 0; i < 20; i++) begin
         step();
         n_total++; if (pc !== 10'h007 || halted !== 1'b1 || mem_req !== 1'b0 || reg_we !== 1'b0)
            $display("FAIL halt_hold: cycle %0d got pc=%h halted=%b req=%b rwe=%b want 007 1 0 0", i, pc, halted, mem_req, reg_we); else n_pass++;
      end
      do_reset();
      n_total++; if (pc !== 10'h000 || halted !== 1'b0 || mem_req !== 1'b1)
         $display("FAIL halt_reset: got pc=%h halted=%b req=%b want 000 0 1", pc, halted, mem_req); else n_pass++;
   endtask

   task automatic test_reset_mid_access();
      wait_n = 3;
      fill_mem(16'h0100);
      mem[0]  = 16'h4502;
      regs[2] = 16'h0040;
      do_reset();
      for (int i = 0; i < 5; i++) step();
      n_total++; if (mem_req !== 1'b1 || mem_addr !== 10'h040)
         $display("FAIL midrst_in_mem: got req=%b addr=%h want 1 040", mem_req, mem_addr); else n_pass++;
      rst = 1'b1;
      step();
      n_total++; if (mem_req !== 1'b0 || reg_we !== 1'b0 || pc !== 10'h000)
         $display("FAIL midrst_abandon: got req=%b rwe=%b pc=%h want 0 0 000", mem_req, reg_we, pc); else n_pass++;
      rst = 1'b0;
      #1;
      n_total++; if (mem_req !== 1'b1 || mem_addr !== 10'h000 || mem_we !== 1'b0)
         $display("FAIL midrst_fetch: got req=%b addr=%h we=%b want 1 000 0", mem_req, mem_addr, mem_we); else n_pass++;
   endtask

   initial begin
      rst   = 1'b1;
      flags = 5'b0;
      for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
      fill_mem(16'h0100);
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_branch();
      test_halt();
      test_reset_mid_access();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
